// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: packs a byte stream into big-endian words,
// writes them to sequential word addresses and holds the CPU in reset until done.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W:0]   WordCount,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemData,
  output logic              CpuReset,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [1:0]          byte_cnt;
  logic [ADDR_W-1:0]   word_addr;
  logic [CNT_W-1:0]    word_cnt;
  logic [CNT_W-1:0]    word_total;
  logic [31:0]         asm_word;
  logic                count_ok;
  logic                accept;
  logic                last_byte;

  assign count_ok  = (WordCount != '0) && (WordCount <= CNT_W'(MAX_WORDS));
  assign accept    = (state == S_LOAD) && RxValid;
  assign last_byte = accept && (byte_cnt == 2'd3);

  // CPU sees reset asynchronously and in the very cycle the loader leaves DONE
  assign CpuReset = Reset || (state != S_DONE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          next_state = count_ok ? S_LOAD : S_ERR;
        end
      end
      S_LOAD: begin
        if (last_byte) begin
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        next_state = ((word_cnt + CNT_W'(1)) == word_total) ? S_DONE : S_LOAD;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they line up with it
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      RxReady    <= 1'b0;
      MemWrite   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      MemAddr    <= '0;
      MemData    <= '0;
      byte_cnt   <= '0;
      word_addr  <= '0;
      word_cnt   <= '0;
      word_total <= '0;
      asm_word   <= '0;
    end else begin
      RxReady  <= (next_state == S_LOAD);
      MemWrite <= (next_state == S_WRITE);
      Busy     <= (next_state == S_LOAD) || (next_state == S_WRITE);
      Done     <= (next_state == S_DONE);
      Error    <= (next_state == S_ERR);
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start && count_ok) begin
            word_total <= WordCount;
            byte_cnt   <= '0;
            word_addr  <= '0;
            word_cnt   <= '0;
            asm_word   <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            asm_word <= {asm_word[23:0], RxData};
            byte_cnt <= byte_cnt + 2'd1;
          end
          if (last_byte) begin
            MemData <= {asm_word[23:0], RxData};
            MemAddr <= word_addr;
          end
        end
        S_WRITE: begin
          word_addr <= word_addr + ADDR_W'(1);
          word_cnt  <= word_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
